// File: rtl/fb_pkg.sv
// rtl/fb_pkg.sv - shared frame-buffer constants, colour fields and FSM state type
// Purpose: constants for the 320x240 12-bit frame buffer and the state
//          encoding shared by the rectangle writer and its interface.
// Ports:   none (package).
package fb_pkg;

  localparam int FB_W      = 320;
  localparam int FB_H      = 240;
  localparam int FB_DEPTH  = FB_W * FB_H;
  localparam int FB_ADDR_W = 17;
  localparam int COLOR_W   = 12;

  // Pixel layout {R[3:0],G[3:0],B[3:0]}
  localparam int R_MSB = 11;
  localparam int R_LSB = 8;
  localparam int G_MSB = 7;
  localparam int G_LSB = 4;
  localparam int B_MSB = 3;
  localparam int B_LSB = 0;

  typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

endpackage

// File: rtl/fb_rect_writer_if.sv
// rtl/fb_rect_writer_if.sv - command and BRAM write-port bundle for the rectangle writer
// Purpose: groups the fill-command handshake, BRAM write port and status.
// Ports (signals):
//   cmd_valid/cmd_ready        command handshake
//   cmd_x/cmd_y/cmd_w/cmd_h    rectangle origin and size
//   cmd_color                  fill colour
//   wea/addra/dina             BRAM write port
//   busy/done                  fill status
// Modports: master = command source / BRAM observer, slave = rectangle writer.
interface fb_rect_writer_if;
  import fb_pkg::*;

  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [8:0]           cmd_x;
  logic [7:0]           cmd_y;
  logic [8:0]           cmd_w;
  logic [7:0]           cmd_h;
  logic [COLOR_W-1:0]   cmd_color;
  logic                 wea;
  logic [FB_ADDR_W-1:0] addra;
  logic [COLOR_W-1:0]   dina;
  logic                 busy;
  logic                 done;

  modport master (
    output cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color,
    input  cmd_ready, wea, addra, dina, busy, done
  );

  modport slave (
    input  cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color,
    output cmd_ready, wea, addra, dina, busy, done
  );

endinterface

// File: rtl/fb_rect_writer.sv
// rtl/fb_rect_writer.sv - rectangle fill engine writing the frame-buffer BRAM port
// Purpose: accepts one rectangle-fill command at a time, clips it to the
//          frame buffer and emits one BRAM write per cycle in row-major order.
// Ports:
//   clk  system clock (BRAM write-port domain)
//   rst  synchronous active-high reset
//   bus  fb_rect_writer_if.slave: command handshake, BRAM write port, busy/done
// Option: FB_RECT_WRITER_WRAP_EN makes columns wrap modulo FB_W (width clamped
//         to FB_W, cmd_x reduced modulo FB_W); undefined gives pure clipping.
module fb_rect_writer
  import fb_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  fb_rect_writer_if.slave bus
);

  localparam logic [9:0] W10 = 10'(FB_W);
  localparam logic [9:0] H10 = 10'(FB_H);

  state_t               state_q, state_d;
  logic [8:0]           x0_q, x0_d;
  logic [8:0]           col_q, col_d;
  logic [8:0]           w_q, w_d;
  logic [8:0]           col_cnt_q, col_cnt_d;
  logic [7:0]           h_q, h_d;
  logic [7:0]           row_cnt_q, row_cnt_d;
  logic [FB_ADDR_W-1:0] row_base_q, row_base_d;
  logic [FB_ADDR_W-1:0] addra_q, addra_d;
  logic [COLOR_W-1:0]   color_q, color_d;
  logic [COLOR_W-1:0]   dina_q, dina_d;
  logic                 wea_q, wea_d;

  // Accept-time geometry, derived straight from the command inputs
  logic [8:0]           acc_x0, acc_w, col_nxt;
  logic [7:0]           acc_h;
  logic [FB_ADDR_W-1:0] acc_base;
  logic [9:0]           y_sum, y_end;
`ifndef FB_RECT_WRITER_WRAP_EN
  logic [9:0]           x_sum, x_end;
`endif

  always_comb begin
    y_sum    = {2'b0, bus.cmd_y} + {2'b0, bus.cmd_h};
    y_end    = (y_sum > H10) ? H10 : y_sum;
    acc_h    = (bus.cmd_y >= 8'(FB_H)) ? 8'd0 : 8'(y_end - {2'b0, bus.cmd_y});
    // y*320 as y*256 + y*64
    acc_base = (FB_ADDR_W'(bus.cmd_y) << 8) + (FB_ADDR_W'(bus.cmd_y) << 6);
`ifdef FB_RECT_WRITER_WRAP_EN
    acc_x0   = ({1'b0, bus.cmd_x} >= W10) ? 9'({1'b0, bus.cmd_x} - W10) : bus.cmd_x;
    acc_w    = ({1'b0, bus.cmd_w} > W10) ? 9'(W10) : bus.cmd_w;
    col_nxt  = (col_q == 9'(FB_W - 1)) ? 9'd0 : col_q + 9'd1;
`else
    x_sum    = {1'b0, bus.cmd_x} + {1'b0, bus.cmd_w};
    x_end    = (x_sum > W10) ? W10 : x_sum;
    acc_x0   = bus.cmd_x;
    acc_w    = ({1'b0, bus.cmd_x} >= W10) ? 9'd0 : 9'(x_end - {1'b0, bus.cmd_x});
    col_nxt  = col_q + 9'd1;
`endif
  end

  // Counters track the pixel currently on the BRAM port; each FILL cycle
  // computes the following pixel so writes stay back-to-back.
  always_comb begin
    state_d    = state_q;
    x0_d       = x0_q;
    col_d      = col_q;
    w_d        = w_q;
    col_cnt_d  = col_cnt_q;
    h_d        = h_q;
    row_cnt_d  = row_cnt_q;
    row_base_d = row_base_q;
    color_d    = color_q;
    addra_d    = addra_q;
    dina_d     = dina_q;
    wea_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          x0_d      = acc_x0;
          w_d       = acc_w;
          h_d       = acc_h;
          color_d   = bus.cmd_color;
          col_d     = acc_x0;
          col_cnt_d = 9'd0;
          row_cnt_d = 8'd0;
          row_base_d = acc_base;
          if (acc_w == 9'd0 || acc_h == 8'd0) begin
            state_d = DONE;
          end else begin
            state_d = FILL;
            wea_d   = 1'b1;
            addra_d = acc_base + FB_ADDR_W'(acc_x0);
            dina_d  = bus.cmd_color;
          end
        end
      end
      FILL: begin
        if (col_cnt_q == w_q - 9'd1 && row_cnt_q == h_q - 8'd1) begin
          state_d = DONE;
        end else begin
          wea_d  = 1'b1;
          dina_d = color_q;
          if (col_cnt_q == w_q - 9'd1) begin
            col_d      = x0_q;
            col_cnt_d  = 9'd0;
            row_cnt_d  = row_cnt_q + 8'd1;
            row_base_d = row_base_q + FB_ADDR_W'(FB_W);
          end else begin
            col_d     = col_nxt;
            col_cnt_d = col_cnt_q + 9'd1;
          end
          addra_d = row_base_d + FB_ADDR_W'(col_d);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      x0_q       <= '0;
      col_q      <= '0;
      w_q        <= '0;
      col_cnt_q  <= '0;
      h_q        <= '0;
      row_cnt_q  <= '0;
      row_base_q <= '0;
      color_q    <= '0;
      addra_q    <= '0;
      dina_q     <= '0;
      wea_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      x0_q       <= x0_d;
      col_q      <= col_d;
      w_q        <= w_d;
      col_cnt_q  <= col_cnt_d;
      h_q        <= h_d;
      row_cnt_q  <= row_cnt_d;
      row_base_q <= row_base_d;
      color_q    <= color_d;
      addra_q    <= addra_d;
      dina_q     <= dina_d;
      wea_q      <= wea_d;
    end
  end

  assign bus.cmd_ready = (state_q == IDLE);
  assign bus.busy      = (state_q == FILL);
  assign bus.done      = (state_q == DONE);
  assign bus.wea       = wea_q;
  assign bus.addra     = addra_q;
  assign bus.dina      = dina_q;

endmodule

// File: tb/tb_fb_rect_writer.sv
// tb/tb_fb_rect_writer.sv - directed self-checking bench for fb_rect_writer
module tb_fb_rect_writer;
  import fb_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fb_rect_writer_if bus ();

  fb_rect_writer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;
  int exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] rgb(input int r, input int g, input int b);
    logic [11:0] c;
    c = '0;
    c[R_MSB:R_LSB] = 4'(r);
    c[G_MSB:G_LSB] = 4'(g);
    c[B_MSB:B_LSB] = 4'(b);
    return c;
  endfunction

  // Called at a negedge with the DUT idle; exp_q holds the expected addresses.
  task automatic run_cmd(input string tag, input logic [8:0] x, input logic [7:0] y,
                         input logic [8:0] w, input logic [7:0] h, input logic [11:0] c);
    int got_q[$];
    int first_wr = 0;
    int last_wr  = 0;
    int done_cyc = 0;
    int n = 0;
    bus.cmd_x     = x;
    bus.cmd_y     = y;
    bus.cmd_w     = w;
    bus.cmd_h     = h;
    bus.cmd_color = c;
    bus.cmd_valid = 1'b1;
    while (!bus.cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_eq({tag, "_ready"}, 32'(bus.cmd_ready), 1);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    for (int k = 1; k <= 80; k++) begin
      if (k > 1) @(negedge clk);
      if (bus.wea) begin
        if (first_wr == 0) begin
          first_wr = k;
          check_eq({tag, "_dina"}, 32'(bus.dina), 32'(c));
          check_eq({tag, "_busy"}, 32'(bus.busy), 1);
        end
        last_wr = k;
        got_q.push_back(int'(bus.addra));
      end
      if (bus.done) begin
        done_cyc = k;
        break;
      end
    end
    check_eq({tag, "_done_seen"}, 32'(done_cyc != 0), 1);
    check_eq({tag, "_nwrites"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      check_eq($sformatf("%s_addr%0d", tag, i), (i < got_q.size()) ? got_q[i] : -1, exp_q[i]);
    if (got_q.size() > 0) begin
      check_eq({tag, "_first_cyc"}, first_wr, 1);
      check_eq({tag, "_last_cyc"}, last_wr, got_q.size());
    end
    check_eq({tag, "_done_cyc"}, done_cyc, got_q.size() + 1);
    @(negedge clk);
    check_eq({tag, "_ready_after"}, 32'(bus.cmd_ready), 1);
    check_eq({tag, "_done_once"}, 32'(bus.done), 0);
    exp_q.delete();
  endtask

  initial begin
    bit [7:1] bb_wea, bb_done, bb_rdy;
    int bb_addr[1:7];
    int ndone;

    rst           = 1'b1;
    bus.cmd_valid = 1'b1;
    bus.cmd_x     = 9'd0;
    bus.cmd_y     = 8'd0;
    bus.cmd_w     = 9'd1;
    bus.cmd_h     = 8'd1;
    bus.cmd_color = 12'hFFF;

    // Reset held with a valid command present
    repeat (3) @(negedge clk);
    check_eq("rst_wea", 32'(bus.wea), 0);
    check_eq("rst_busy", 32'(bus.busy), 0);
    bus.cmd_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check_eq("rel_ready", 32'(bus.cmd_ready), 1);
    check_eq("rel_wea", 32'(bus.wea), 0);
    check_eq("rel_addra", 32'(bus.addra), 0);
    check_eq("rel_dina", 32'(bus.dina), 0);
    check_eq("rel_busy", 32'(bus.busy), 0);
    check_eq("rel_done", 32'(bus.done), 0);

    // Basic 3x2 fill
    exp_q = '{650, 651, 652, 970, 971, 972};
    run_cmd("basic", 9'd10, 8'd2, 9'd3, 8'd2, rgb(15, 0, 0));

    // Bottom-right corner
`ifdef FB_RECT_WRITER_WRAP_EN
    exp_q = '{76798, 76799, 76480, 76481, 76482};
`else
    exp_q = '{76798, 76799};
`endif
    run_cmd("corner", 9'd318, 8'd239, 9'd5, 8'd5, rgb(0, 15, 0));

    // Last column, two rows
    exp_q = '{319, 639};
    run_cmd("lastcol", 9'd319, 8'd0, 9'd1, 8'd2, 12'h00F);

    // Empty: zero width, row off screen, column off screen
    run_cmd("w0", 9'd5, 8'd5, 9'd0, 8'd3, 12'h123);
    run_cmd("y240", 9'd0, 8'd240, 9'd2, 8'd2, 12'h456);
`ifdef FB_RECT_WRITER_WRAP_EN
    exp_q = '{80, 81};
`endif
    run_cmd("x400", 9'd400, 8'd0, 9'd2, 8'd1, 12'h789);

    // Back-to-back: second command held valid during the first fill
    bb_wea  = 7'b0010011;
    bb_done = 7'b0100100;
    bb_rdy  = 7'b1001000;
    bb_addr = '{0, 1, 0, 0, 325, 0, 0};
    ndone   = 0;
    bus.cmd_x = 9'd0; bus.cmd_y = 8'd0; bus.cmd_w = 9'd2; bus.cmd_h = 8'd1;
    bus.cmd_color = 12'h111;
    bus.cmd_valid = 1'b1;
    @(negedge clk);
    bus.cmd_x = 9'd5; bus.cmd_y = 8'd1; bus.cmd_w = 9'd1; bus.cmd_h = 8'd1;
    bus.cmd_color = 12'h222;
    for (int k = 1; k <= 7; k++) begin
      check_eq($sformatf("b2b_wea%0d", k), 32'(bus.wea), 32'(bb_wea[k]));
      if (bb_wea[k]) check_eq($sformatf("b2b_addr%0d", k), 32'(bus.addra), bb_addr[k]);
      check_eq($sformatf("b2b_done%0d", k), 32'(bus.done), 32'(bb_done[k]));
      check_eq($sformatf("b2b_ready%0d", k), 32'(bus.cmd_ready), 32'(bb_rdy[k]));
      if (bus.done) ndone++;
      if (k == 5) bus.cmd_valid = 1'b0;
      @(negedge clk);
    end
    check_eq("b2b_ndone", ndone, 2);

    // Reset during the 4th write of a 4x4 fill
    bus.cmd_x = 9'd0; bus.cmd_y = 8'd0; bus.cmd_w = 9'd4; bus.cmd_h = 8'd4;
    bus.cmd_color = 12'hABC;
    bus.cmd_valid = 1'b1;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      check_eq($sformatf("mid_wea%0d", k), 32'(bus.wea), 1);
      check_eq($sformatf("mid_addr%0d", k), 32'(bus.addra), k - 1);
      if (k < 4) @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    check_eq("mid_rst_wea", 32'(bus.wea), 0);
    check_eq("mid_rst_done", 32'(bus.done), 0);
    check_eq("mid_rst_busy", 32'(bus.busy), 0);
    check_eq("mid_rst_ready", 32'(bus.cmd_ready), 1);
    rst = 1'b0;
    @(negedge clk);
    check_eq("mid_after_done", 32'(bus.done), 0);
    check_eq("mid_after_wea", 32'(bus.wea), 0);

    exp_q = '{32100, 32101};
    run_cmd("post_rst", 9'd100, 8'd100, 9'd2, 8'd1, 12'h0F0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
